vliw_fwd_unit: RTL and testbench

//  Parametrised N-lane forwarding/hazard unit for the STARBUG VLIW integer pipeline.

---
 rtl/vliw_fwd_unit_pkg.sv | 28 ++
 rtl/vliw_fwd_unit_sel.sv | 94 +++++++++
 rtl/vliw_fwd_unit.sv | 214 +++++++++++++++++++++
 tb/tb_vliw_fwd_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vliw_fwd_unit_pkg.sv
// ---------------------------------------------------------------------------
// Package: vliw_fwd_unit_pkg
// Purpose: shared types and constants for the STARBUG VLIW forwarding unit.
//   fwd_src_t       - bypass source selected for one operand
//   VLIW_MAX_LANES  - widest bundle the unit is built for
//   REG_AW          - integer register address width
//   reg_match()     - "this stage/lane produces register rs" test
// ---------------------------------------------------------------------------
package vliw_fwd_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10,
    FWD_R  = 2'b11
  } fwd_src_t;

  localparam int VLIW_MAX_LANES = 8;
  localparam int REG_AW         = 5;

  // x0 is hardwired to zero, so a write to it never forwards.
  function automatic logic reg_match(input logic             wr,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
    return wr && (rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/vliw_fwd_unit_sel.sv
// ---------------------------------------------------------------------------
// Module: vliw_fwd_sel
// Purpose: priority select for a single operand. Reports which pipeline stage
//   and which lane supply the freshest copy of register rs.
// Ports:
//   rs                 in   operand source register
//   rd_m, regwrite_m   in   per-lane Memory-stage destination / valid
//   load_m             in   per-lane Memory-stage load flag
//   rd_w, regwrite_w   in   per-lane Writeback-stage destination / valid
//   rd_r, regwrite_r   in   per-lane retire-stage destination / valid
//                           (only with VLIW_FWD_RETIRE_EN)
//   src                out  selected source stage
//   lane               out  producing lane within that stage
//   load_hit           out  operand matched a load still sitting in M
// Configuration: VLIW_FWD_RETIRE_EN adds the retire stage as lowest bypass.
// ---------------------------------------------------------------------------
module vliw_fwd_sel
  import vliw_fwd_unit_pkg::*;
#(
  parameter  int LANES = 4,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [REG_AW-1:0]             rs,
  input  logic [LANES-1:0][REG_AW-1:0]  rd_m,
  input  logic [LANES-1:0]              regwrite_m,
  input  logic [LANES-1:0]              load_m,
  input  logic [LANES-1:0][REG_AW-1:0]  rd_w,
  input  logic [LANES-1:0]              regwrite_w,
`ifdef VLIW_FWD_RETIRE_EN
  input  logic [LANES-1:0][REG_AW-1:0]  rd_r,
  input  logic [LANES-1:0]              regwrite_r,
`endif
  output fwd_src_t                      src,
  output logic [LW-1:0]                 lane,
  output logic                          load_hit
);

  logic          hit_m, hit_w;
  logic [LW-1:0] lane_m, lane_w;
`ifdef VLIW_FWD_RETIRE_EN
  logic          hit_r;
  logic [LW-1:0] lane_r;
`endif

  // Scan lanes in ascending order so the highest-index (youngest) match wins.
  always_comb begin
    hit_m    = 1'b0;
    lane_m   = '0;
    hit_w    = 1'b0;
    lane_w   = '0;
    load_hit = 1'b0;
`ifdef VLIW_FWD_RETIRE_EN
    hit_r    = 1'b0;
    lane_r   = '0;
`endif
    for (int l = 0; l < LANES; l++) begin
      if (reg_match(regwrite_m[l], rd_m[l], rs)) begin
        hit_m  = 1'b1;
        lane_m = LW'(l);
        if (load_m[l]) load_hit = 1'b1;
      end
      if (reg_match(regwrite_w[l], rd_w[l], rs)) begin
        hit_w  = 1'b1;
        lane_w = LW'(l);
      end
`ifdef VLIW_FWD_RETIRE_EN
      if (reg_match(regwrite_r[l], rd_r[l], rs)) begin
        hit_r  = 1'b1;
        lane_r = LW'(l);
      end
`endif
    end
  end

  // Stage priority: M over W (over R) over the register file.
  always_comb begin
    src  = FWD_RF;
    lane = '0;
    if (hit_m) begin
      src  = FWD_M;
      lane = lane_m;
    end else if (hit_w) begin
      src  = FWD_W;
      lane = lane_w;
    end
`ifdef VLIW_FWD_RETIRE_EN
    else if (hit_r) begin
      src  = FWD_R;
      lane = lane_r;
    end
`endif
  end

endmodule

// File: rtl/vliw_fwd_unit.sv
// ---------------------------------------------------------------------------
// Module: vliw_fwd_unit
// Purpose: N-lane forwarding / load-use hazard unit for the STARBUG VLIW
//   integer pipeline. Tracks each lane's destination through M and W and
//   picks the bypass source for both operands of every Execute lane.
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   StallE/M/W           bundle-wide stage stalls
//   FlushE/M/W           bundle-wide stage flushes
//   Rs1D, Rs2D           Decode sources (load-use check)
//   Rs1E, Rs2E, RdE      Execute sources / destination
//   RegWriteE, LoadE     Execute lane writes regfile / is a load
//   R1E, R2E             regfile operands already in E
//   IFResultM, ResultW   per-lane M and W results
//   SrcAFwdE, SrcBFwdE   forwarded operands
//   LoadUseStallD        stall F/D and flush E request
// Configuration: VLIW_FWD_RETIRE_EN adds a retire stage (R) below W for
//   register files without write-before-read.
// ---------------------------------------------------------------------------
module vliw_fwd_unit
  import vliw_fwd_unit_pkg::*;
#(
  parameter  int XLEN  = 64,
  parameter  int LANES = 4,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            StallE,
  input  logic                            StallM,
  input  logic                            StallW,
  input  logic                            FlushE,
  input  logic                            FlushM,
  input  logic                            FlushW,
  input  logic [LANES-1:0][REG_AW-1:0]    Rs1D,
  input  logic [LANES-1:0][REG_AW-1:0]    Rs2D,
  input  logic [LANES-1:0][REG_AW-1:0]    Rs1E,
  input  logic [LANES-1:0][REG_AW-1:0]    Rs2E,
  input  logic [LANES-1:0][REG_AW-1:0]    RdE,
  input  logic [LANES-1:0]                RegWriteE,
  input  logic [LANES-1:0]                LoadE,
  input  logic [LANES-1:0][XLEN-1:0]      R1E,
  input  logic [LANES-1:0][XLEN-1:0]      R2E,
  input  logic [LANES-1:0][XLEN-1:0]      IFResultM,
  input  logic [LANES-1:0][XLEN-1:0]      ResultW,
  output logic [LANES-1:0][XLEN-1:0]      SrcAFwdE,
  output logic [LANES-1:0][XLEN-1:0]      SrcBFwdE,
  output logic                            LoadUseStallD
);

  if (LANES < 2 || LANES > VLIW_MAX_LANES) begin : g_bad_lanes
    $error("vliw_fwd_unit: LANES out of range");
  end

  // The E stage register itself lives in the lane datapaths; its stall and
  // flush act there, so this unit only carries them for a uniform interface.
  logic unused_e_ctrl;
  assign unused_e_ctrl = StallE | FlushE;

  logic [LANES-1:0][REG_AW-1:0] rd_m_q, rd_m_d, rd_w_q, rd_w_d;
  logic [LANES-1:0]             regwrite_m_q, regwrite_m_d;
  logic [LANES-1:0]             load_m_q, load_m_d;
  logic [LANES-1:0]             regwrite_w_q, regwrite_w_d;
`ifdef VLIW_FWD_RETIRE_EN
  logic [LANES-1:0][REG_AW-1:0] rd_r_q, rd_r_d;
  logic [LANES-1:0]             regwrite_r_q, regwrite_r_d;
  logic [LANES-1:0][XLEN-1:0]   result_r_q, result_r_d;
`endif

  // Stage advance; a flush clears the valid bits even while stalled.
  always_comb begin
    rd_m_d       = rd_m_q;
    regwrite_m_d = regwrite_m_q;
    load_m_d     = load_m_q;
    rd_w_d       = rd_w_q;
    regwrite_w_d = regwrite_w_q;
    if (!StallM) begin
      rd_m_d       = RdE;
      regwrite_m_d = RegWriteE;
      load_m_d     = LoadE;
    end
    if (FlushM) begin
      regwrite_m_d = '0;
      load_m_d     = '0;
    end
    if (!StallW) begin
      rd_w_d       = rd_m_q;
      regwrite_w_d = regwrite_m_q;
    end
    if (FlushW) regwrite_w_d = '0;
  end

`ifdef VLIW_FWD_RETIRE_EN
  // Retire stage captures what W is writing back this cycle.
  always_comb begin
    rd_r_d       = rd_r_q;
    regwrite_r_d = regwrite_r_q;
    result_r_d   = result_r_q;
    if (!StallW) begin
      rd_r_d       = rd_w_q;
      regwrite_r_d = regwrite_w_q;
      result_r_d   = ResultW;
    end
    if (FlushW) regwrite_r_d = '0;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_m_q       <= '0;
      regwrite_m_q <= '0;
      load_m_q     <= '0;
      rd_w_q       <= '0;
      regwrite_w_q <= '0;
`ifdef VLIW_FWD_RETIRE_EN
      rd_r_q       <= '0;
      regwrite_r_q <= '0;
      result_r_q   <= '0;
`endif
    end else begin
      rd_m_q       <= rd_m_d;
      regwrite_m_q <= regwrite_m_d;
      load_m_q     <= load_m_d;
      rd_w_q       <= rd_w_d;
      regwrite_w_q <= regwrite_w_d;
`ifdef VLIW_FWD_RETIRE_EN
      rd_r_q       <= rd_r_d;
      regwrite_r_q <= regwrite_r_d;
      result_r_q   <= result_r_d;
`endif
    end
  end

  fwd_src_t          src_a [LANES];
  fwd_src_t          src_b [LANES];
  logic [LW-1:0]     lane_a [LANES];
  logic [LW-1:0]     lane_b [LANES];
  logic [LANES-1:0]  load_hit_a, load_hit_b;

  for (genvar g = 0; g < LANES; g++) begin : g_sel
    vliw_fwd_sel #(.LANES(LANES)) u_sel_a (
      .rs         (Rs1E[g]),
      .rd_m       (rd_m_q),
      .regwrite_m (regwrite_m_q),
      .load_m     (load_m_q),
      .rd_w       (rd_w_q),
      .regwrite_w (regwrite_w_q),
`ifdef VLIW_FWD_RETIRE_EN
      .rd_r       (rd_r_q),
      .regwrite_r (regwrite_r_q),
`endif
      .src        (src_a[g]),
      .lane       (lane_a[g]),
      .load_hit   (load_hit_a[g])
    );
    vliw_fwd_sel #(.LANES(LANES)) u_sel_b (
      .rs         (Rs2E[g]),
      .rd_m       (rd_m_q),
      .regwrite_m (regwrite_m_q),
      .load_m     (load_m_q),
      .rd_w       (rd_w_q),
      .regwrite_w (regwrite_w_q),
`ifdef VLIW_FWD_RETIRE_EN
      .rd_r       (rd_r_q),
      .regwrite_r (regwrite_r_q),
`endif
      .src        (src_b[g]),
      .lane       (lane_b[g]),
      .load_hit   (load_hit_b[g])
    );
  end

  // AND-OR mux from one-hot decoded selects: exactly one term is enabled per
  // operand, so no X from an unselected source can leak into the result.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      SrcAFwdE[l] = R1E[l] & {XLEN{src_a[l] == FWD_RF}};
      SrcBFwdE[l] = R2E[l] & {XLEN{src_b[l] == FWD_RF}};
      for (int k = 0; k < LANES; k++) begin
        SrcAFwdE[l] = SrcAFwdE[l]
                    | (IFResultM[k] & {XLEN{src_a[l] == FWD_M && lane_a[l] == LW'(k)}})
                    | (ResultW[k]   & {XLEN{src_a[l] == FWD_W && lane_a[l] == LW'(k)}});
        SrcBFwdE[l] = SrcBFwdE[l]
                    | (IFResultM[k] & {XLEN{src_b[l] == FWD_M && lane_b[l] == LW'(k)}})
                    | (ResultW[k]   & {XLEN{src_b[l] == FWD_W && lane_b[l] == LW'(k)}});
`ifdef VLIW_FWD_RETIRE_EN
        SrcAFwdE[l] = SrcAFwdE[l]
                    | (result_r_q[k] & {XLEN{src_a[l] == FWD_R && lane_a[l] == LW'(k)}});
        SrcBFwdE[l] = SrcBFwdE[l]
                    | (result_r_q[k] & {XLEN{src_b[l] == FWD_R && lane_b[l] == LW'(k)}});
`endif
      end
    end
  end

  // Load data only exists after M, so any Decode consumer of an E-stage load
  // (in any lane) must wait one cycle.
  always_comb begin
    LoadUseStallD = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (LoadE[i] && RegWriteE[i] && RdE[i] != '0 &&
            (RdE[i] == Rs1D[j] || RdE[i] == Rs2D[j]))
          LoadUseStallD = 1'b1;
      end
    end
  end

  // A load reaching M with a dependent in E means the load-use stall was missed.
  a_no_load_fwd_from_m : assert property (
    @(posedge clk) disable iff (!reset) ((load_hit_a | load_hit_b) == '0)
  );

endmodule

// File: tb/tb_vliw_fwd_unit.sv
// ---------------------------------------------------------------------------
// Testbench: tb_vliw_fwd_unit
// Directed checks of the forwarding unit (XLEN=64, LANES=4). Build with
// VLIW_FWD_RETIRE_EN defined to exercise the retire-stage bypass.
// ---------------------------------------------------------------------------
module tb_vliw_fwd_unit;

  localparam int XLEN  = 64;
  localparam int LANES = 4;

  logic clk;
  logic reset;
  logic stall_e, stall_m, stall_w, flush_e, flush_m, flush_w;
  logic [LANES-1:0][4:0]      rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
  logic [LANES-1:0]           regwrite_e, load_e;
  logic [LANES-1:0][XLEN-1:0] r1_e, r2_e, if_result_m, result_w;
  logic [LANES-1:0][XLEN-1:0] src_a_fwd_e, src_b_fwd_e;
  logic                       load_use_stall_d;

  int checks   = 0;
  int failures = 0;

  vliw_fwd_unit #(.XLEN(XLEN), .LANES(LANES)) dut (
    .clk           (clk),
    .reset         (reset),
    .StallE        (stall_e),
    .StallM        (stall_m),
    .StallW        (stall_w),
    .FlushE        (flush_e),
    .FlushM        (flush_m),
    .FlushW        (flush_w),
    .Rs1D          (rs1_d),
    .Rs2D          (rs2_d),
    .Rs1E          (rs1_e),
    .Rs2E          (rs2_e),
    .RdE           (rd_e),
    .RegWriteE     (regwrite_e),
    .LoadE         (load_e),
    .R1E           (r1_e),
    .R2E           (r2_e),
    .IFResultM     (if_result_m),
    .ResultW       (result_w),
    .SrcAFwdE      (src_a_fwd_e),
    .SrcBFwdE      (src_b_fwd_e),
    .LoadUseStallD (load_use_stall_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Default operand values are tagged by source and lane.
  task automatic clearInputs();
    stall_e = 0; stall_m = 0; stall_w = 0;
    flush_e = 0; flush_m = 0; flush_w = 0;
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
    regwrite_e = '0; load_e = '0;
    for (int l = 0; l < LANES; l++) begin
      r1_e[l]        = 64'h1111_0000_0000_0000 | 64'(l);
      r2_e[l]        = 64'h2222_0000_0000_0000 | 64'(l);
      if_result_m[l] = 64'hCCCC_0000_0000_0000 | 64'(l);
      result_w[l]    = 64'hDDDD_0000_0000_0000 | 64'(l);
    end
  endtask

  // Advance one clock with the currently driven inputs; land 1 unit past the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b0;
    clearInputs();
    #1;
    checkOutput("reset_srcA0", src_a_fwd_e[0], 64'h1111_0000_0000_0000);
    checkOutput("reset_srcB3", src_b_fwd_e[3], 64'h2222_0000_0000_0003);
    checkOutput("reset_stall", 64'(load_use_stall_d), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Mid-stream reset forgets an in-flight x5
    regwrite_e[0] = 1; rd_e[0] = 5;
    applyStimulus();
    clearInputs();
    rs1_e[1] = 5;
    #1;
    checkOutput("pre_reset_fwd_m", src_a_fwd_e[1], 64'hCCCC_0000_0000_0000);
    reset = 1'b0;
    #1;
    checkOutput("async_reset_rf", src_a_fwd_e[1], 64'h1111_0000_0000_0001);
    reset = 1'b1;
    applyStimulus();

    // Lane0 writes x7, lane2 reads it from M, then from W
    clearInputs();
    regwrite_e[0] = 1; rd_e[0] = 7;
    applyStimulus();
    clearInputs();
    if_result_m[0] = 64'h11; rs2_e[2] = 7;
    #1;
    checkOutput("m_fwd_x7", src_b_fwd_e[2], 64'h11);
    applyStimulus();
    result_w[0] = 64'h77;
    #1;
    checkOutput("w_fwd_x7", src_b_fwd_e[2], 64'h77);

    // Lanes 1 and 3 both write x9: higher lane wins in M and in W
    clearInputs();
    regwrite_e[1] = 1; rd_e[1] = 9; regwrite_e[3] = 1; rd_e[3] = 9;
    applyStimulus();
    clearInputs();
    if_result_m[1] = 64'hA; if_result_m[3] = 64'hB; rs1_e[0] = 9;
    #1;
    checkOutput("m_lane_prio_x9", src_a_fwd_e[0], 64'hB);
    applyStimulus();
    result_w[1] = 64'hA0; result_w[3] = 64'hB0;
    #1;
    checkOutput("w_lane_prio_x9", src_a_fwd_e[0], 64'hB0);

    // x4 in both M and W: M wins
    clearInputs();
    regwrite_e[0] = 1; rd_e[0] = 4;
    applyStimulus();
    clearInputs();
    regwrite_e[2] = 1; rd_e[2] = 4;
    applyStimulus();
    clearInputs();
    if_result_m[2] = 64'h22; result_w[0] = 64'h33;
    rs1_e[1] = 4; rs2_e[1] = 4;
    #1;
    checkOutput("m_over_w_a", src_a_fwd_e[1], 64'h22);
    checkOutput("m_over_w_b", src_b_fwd_e[1], 64'h22);

    // Write to x0 never forwards
    clearInputs();
    regwrite_e[1] = 1; rd_e[1] = 0;
    applyStimulus();
    clearInputs();
    rs1_e[3] = 0;
    #1;
    checkOutput("x0_no_fwd", src_a_fwd_e[3], 64'h1111_0000_0000_0003);

    // Load-use detection
    clearInputs();
    load_e[1] = 1; regwrite_e[1] = 1; rd_e[1] = 12; rs2_d[3] = 12;
    #1;
    checkOutput("load_use_hit", 64'(load_use_stall_d), 64'd1);
    rd_e[1] = 0; rs2_d[3] = 0;
    #1;
    checkOutput("load_use_rd0", 64'(load_use_stall_d), 64'd0);
    rd_e[1] = 12; rs1_d[0] = 13;
    #1;
    checkOutput("load_use_miss", 64'(load_use_stall_d), 64'd0);
    clearInputs();
    applyStimulus();
    applyStimulus();

    // x6 retires while a flushed x6 writer enters M
    clearInputs();
    regwrite_e[0] = 1; rd_e[0] = 6;
    applyStimulus();
    clearInputs();
    applyStimulus();
    clearInputs();
    result_w[0] = 64'h66;
    regwrite_e[1] = 1; rd_e[1] = 6; flush_m = 1;
    applyStimulus();
    clearInputs();
    rs1_e[0] = 6;
    #1;
`ifdef VLIW_FWD_RETIRE_EN
    checkOutput("flush_m_retire", src_a_fwd_e[0], 64'h66);
`else
    checkOutput("flush_m_rf", src_a_fwd_e[0], 64'h1111_0000_0000_0000);
`endif

    // StallM holds M; then flush beats stall
    clearInputs();
    regwrite_e[2] = 1; rd_e[2] = 3;
    applyStimulus();
    stall_m = 1; rd_e[2] = 8;
    applyStimulus();
    rs1_e[0] = 3; rs2_e[0] = 8;
    #1;
    checkOutput("stall_m_hold", src_a_fwd_e[0], 64'hCCCC_0000_0000_0002);
    checkOutput("stall_m_nocap", src_b_fwd_e[0], 64'h2222_0000_0000_0000);
    flush_m = 1;
    applyStimulus();
    #1;
    checkOutput("flush_over_stall", src_a_fwd_e[0], 64'hDDDD_0000_0000_0002);
    clearInputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
